// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, bit indices and FSM state types for apb_uart_fifo
package uart_pkg;

   localparam logic [5:0] ADDR_DATA = 6'h00;
   localparam logic [5:0] ADDR_STAT = 6'h01;
   localparam logic [5:0] ADDR_CTRL = 6'h02;
   localparam logic [5:0] ADDR_BAUD = 6'h03;

   localparam int STAT_TX_EMPTY = 0;
   localparam int STAT_TX_FULL  = 1;
   localparam int STAT_RX_EMPTY = 2;
   localparam int STAT_RX_FULL  = 3;
   localparam int STAT_TX_BUSY  = 4;
   localparam int STAT_OVERRUN  = 5;
   localparam int STAT_FRAME    = 6;
   localparam int STAT_PARITY   = 7;

   localparam int CTRL_TX_EN     = 0;
   localparam int CTRL_RX_EN     = 1;
   localparam int CTRL_PAR_EN    = 2;
   localparam int CTRL_PAR_ODD   = 3;
   localparam int CTRL_IE_RX     = 4;
   localparam int CTRL_IE_TX     = 5;
   localparam int CTRL_IE_ERR    = 6;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with wrap-bit pointers and fall-through read data
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic [WIDTH-1:0] mem [DEPTH];

   // Caller guarantees push only with space (or a same-cycle pop) and pop only when non-empty.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge pclk) begin
      if (push) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[AW-1:0]];
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/apb_uart_fifo.sv
// rtl/apb_uart_fifo.sv - APB3 UART with TX/RX FIFOs, programmable baud and optional parity
module apb_uart_fifo
   import uart_pkg::*;
#(
   parameter int          DATA_W     = 8,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RST    = 16'd26
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [7:0]  paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   input  logic        rx,
   output logic        tx,
   output logic        irq
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

   logic [6:0]  ctrl;
   logic [15:0] div;
   logic [15:0] baud_cnt;
   logic        tick;
   logic        ovr, ferr, perr;
   logic        ovr_set;
   logic [2:0]  w1c;

   logic              tx_push, tx_pop, tx_empty, tx_full;
   logic [DATA_W-1:0] tx_rdata;
   logic              rx_push, rx_push_ok, rx_pop, rx_empty, rx_full;
   logic [DATA_W-1:0] rx_rdata;

   logic        access, wr_en, rd_en, sel_data, mapped;
   logic [5:0]  reg_idx;
   logic [7:0]  stat;
   logic        unused_bits;

   assign unused_bits = ^{pwdata[31:16], paddr[1:0]};

   assign access   = psel & penable;
   assign wr_en    = access & pwrite;
   assign rd_en    = access & ~pwrite;
   assign reg_idx  = paddr[7:2];
   assign sel_data = (reg_idx == ADDR_DATA);
   assign mapped   = (reg_idx <= ADDR_BAUD);
   assign pready   = access;

   assign tx_push = wr_en & sel_data & ~tx_full;
   assign rx_pop  = rd_en & sel_data & ~rx_empty;
   assign pslverr = access & (~mapped | (sel_data & pwrite & tx_full) | (sel_data & ~pwrite & rx_empty));
   assign w1c     = (wr_en && reg_idx == ADDR_STAT) ? pwdata[7:5] : 3'b000;

   tx_state_t         tx_state, tx_state_d;
   rx_state_t         rx_state, rx_state_d;
   assign stat = {perr, ferr, ovr, (tx_state != TX_IDLE), rx_full, rx_empty, tx_full, tx_empty};

   always_comb begin
      prdata = '0;
      if (rd_en) begin
         case (reg_idx)
            ADDR_DATA: if (!rx_empty) prdata[DATA_W-1:0] = rx_rdata;
            ADDR_STAT: prdata[7:0]  = stat;
            ADDR_CTRL: prdata[6:0]  = ctrl;
            ADDR_BAUD: prdata[15:0] = div;
            default:   prdata = '0;
         endcase
      end
   end

   // A BAUD write restarts the tick phase so the new rate applies at once.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         ctrl     <= '0;
         div      <= DIV_RST;
         baud_cnt <= DIV_RST;
      end else begin
         if (wr_en && reg_idx == ADDR_CTRL) ctrl <= pwdata[6:0];
         if (wr_en && reg_idx == ADDR_BAUD) begin
            div      <= pwdata[15:0];
            baud_cnt <= pwdata[15:0];
         end else if (tick) begin
            baud_cnt <= div;
         end else begin
            baud_cnt <= baud_cnt - 1'b1;
         end
      end
   end

   assign tick = (baud_cnt == 16'd0);

   uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .pclk(pclk), .presetn(presetn), .push(tx_push), .wdata(pwdata[DATA_W-1:0]),
      .pop(tx_pop), .rdata(tx_rdata), .empty(tx_empty), .full(tx_full)
   );

   logic              rx_shreg_unused;
   logic [DATA_W-1:0] rx_sh;
   assign rx_shreg_unused = 1'b0;

   uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .pclk(pclk), .presetn(presetn), .push(rx_push_ok), .wdata(rx_sh),
      .pop(rx_pop), .rdata(rx_rdata), .empty(rx_empty), .full(rx_full)
   );

   // ---------------- transmitter ----------------
   logic [3:0]        tx_tcnt;
   logic [2:0]        tx_bit;
   logic [DATA_W-1:0] tx_sh;
   logic              tx_par, tx_par_en, tx_d, tx_q, tx_last;

   assign tx_last = tick & (tx_tcnt == 4'd15);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) tx_state <= TX_IDLE;
      else          tx_state <= tx_state_d;
   end

   always_comb begin
      tx_state_d = tx_state;
      case (tx_state)
         TX_IDLE:   if (ctrl[CTRL_TX_EN] && !tx_empty) tx_state_d = TX_START;
         TX_START:  if (tx_last) tx_state_d = TX_DATA;
         TX_DATA:   if (tx_last && tx_bit == LAST_BIT) tx_state_d = tx_par_en ? TX_PARITY : TX_STOP;
         TX_PARITY: if (tx_last) tx_state_d = TX_STOP;
         TX_STOP:   if (tx_last) tx_state_d = TX_IDLE;
         default:   tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_d   = 1'b1;
      tx_pop = (tx_state == TX_IDLE) && (tx_state_d == TX_START);
      case (tx_state)
         TX_START:  tx_d = 1'b0;
         TX_DATA:   tx_d = tx_sh[0];
         TX_PARITY: tx_d = tx_par;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         tx_q      <= 1'b1;
         tx_tcnt   <= '0;
         tx_bit    <= '0;
         tx_sh     <= '0;
         tx_par    <= 1'b0;
         tx_par_en <= 1'b0;
      end else begin
         tx_q <= tx_d;
         if (tx_state_d != tx_state) tx_tcnt <= '0;
         else if (tick)              tx_tcnt <= tx_tcnt + 1'b1;
         if (tx_pop) begin
            tx_sh     <= tx_rdata;
            tx_par    <= (^tx_rdata) ^ ctrl[CTRL_PAR_ODD];
            tx_par_en <= ctrl[CTRL_PAR_EN];
            tx_bit    <= '0;
         end else if (tx_state == TX_DATA && tx_last) begin
            tx_sh  <= tx_sh >> 1;
            tx_bit <= tx_bit + 1'b1;
         end
      end
   end

   assign tx = tx_q;

   // ---------------- receiver ----------------
   logic       rx_s1, rx_s2, rx_prev, rx_fall, rx_samp, rx_last;
   logic [3:0] rx_tcnt;
   logic [2:0] rx_bit;
   logic       rx_par_en, rx_par_odd, ferr_set, perr_set;

   assign rx_fall = rx_prev & ~rx_s2;
   assign rx_samp = tick & (rx_tcnt == 4'd7);
   assign rx_last = tick & (rx_tcnt == 4'd15);

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) rx_state <= RX_IDLE;
      else          rx_state <= rx_state_d;
   end

   // Stop ends at its mid-bit sample so a back-to-back start edge is never missed.
   always_comb begin
      rx_state_d = rx_state;
      case (rx_state)
         RX_IDLE:   if (ctrl[CTRL_RX_EN] && rx_fall) rx_state_d = RX_START;
         RX_START:  if (rx_samp && rx_s2) rx_state_d = RX_IDLE;
                    else if (rx_last) rx_state_d = RX_DATA;
         RX_DATA:   if (rx_last && rx_bit == LAST_BIT) rx_state_d = rx_par_en ? RX_PARITY : RX_STOP;
         RX_PARITY: if (rx_last) rx_state_d = RX_STOP;
         RX_STOP:   if (rx_samp) rx_state_d = RX_IDLE;
         default:   rx_state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_push  = (rx_state == RX_STOP) && rx_samp;
      ferr_set = rx_push & ~rx_s2;
      perr_set = (rx_state == RX_PARITY) && rx_samp && (rx_s2 != ((^rx_sh) ^ rx_par_odd));
   end

   assign rx_push_ok = rx_push & (~rx_full | rx_pop);
   assign ovr_set    = rx_push & rx_full & ~rx_pop;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_prev    <= 1'b1;
         rx_tcnt    <= '0;
         rx_bit     <= '0;
         rx_sh      <= '0;
         rx_par_en  <= 1'b0;
         rx_par_odd <= 1'b0;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         if (rx_state_d != rx_state) rx_tcnt <= '0;
         else if (tick)              rx_tcnt <= rx_tcnt + 1'b1;
         if (rx_state == RX_IDLE && rx_state_d == RX_START) begin
            rx_bit     <= '0;
            rx_par_en  <= ctrl[CTRL_PAR_EN];
            rx_par_odd <= ctrl[CTRL_PAR_ODD];
         end else if (rx_state == RX_DATA) begin
            if (rx_samp) rx_sh  <= {rx_s2, rx_sh[DATA_W-1:1]};
            if (rx_last) rx_bit <= rx_bit + 1'b1;
         end
      end
   end

   // Sticky flags: a new event in the same cycle as its W1C keeps the flag set.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         ovr  <= 1'b0;
         ferr <= 1'b0;
         perr <= 1'b0;
         irq  <= 1'b0;
      end else begin
         ovr  <= (ovr  & ~w1c[0]) | ovr_set;
         ferr <= (ferr & ~w1c[1]) | ferr_set;
         perr <= (perr & ~w1c[2]) | perr_set;
         irq  <= (ctrl[CTRL_IE_RX] & ~rx_empty) | (ctrl[CTRL_IE_TX] & tx_empty) |
                 (ctrl[CTRL_IE_ERR] & (ovr | ferr | perr)) | rx_shreg_unused;
      end
   end

endmodule
